// File: rtl/ex_stage_pkg.sv
// Shared definitions for the MIPS execute stage: ALUop and funct encodings,
// the internal ALU operation enum, and bit positions inside the control bundles.
package ex_stage_pkg;

  // ALUop field values produced by the main decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores: address add
  localparam logic [1:0] ALUOP_SUB   = 2'b01;  // beq: compare by subtraction
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // R-type: look at funct
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;  // immediate add

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Operation actually performed by the ALU
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_NOR = 4'd4,
    ALU_SLT = 4'd5
  } alu_op_e;

  // ctrl_in = {ALUsrc, ALUop[1:0], RegDst, PCSrc, memRead, memWrite, MemtoReg, RegWrite}
  localparam int CTRL_IN_W     = 9;
  localparam int CTRL_ALUSRC   = 8;
  localparam int CTRL_ALUOP_HI = 7;
  localparam int CTRL_ALUOP_LO = 6;
  localparam int CTRL_REGDST   = 5;
  localparam int CTRL_PCSRC    = 4;

  // ctrl_out = {memRead, memWrite, MemtoReg, RegWrite}; the low nibble of ctrl_in
  localparam int CTRL_OUT_W    = 4;
  localparam int CTRL_REGWRITE = 0;

endpackage

// File: rtl/ex_stage_alu_ctrl.sv
// ALU control decode: maps the ALUop field and the R-type funct code to the
// operation the ALU performs. Purely combinational.
import ex_stage_pkg::*;

module alu_ctrl (
  input  logic [1:0] alu_op_sel,
  input  logic [5:0] funct,
  output alu_op_e    alu_op
);

  // Decode ALUop, falling through to funct only for R-type instructions
  always_comb begin
    // NOTE: assign a default before the case so every path drives alu_op and no latch is inferred.
    alu_op = ALU_ADD;
    unique case (alu_op_sel)
      ALUOP_ADD:  alu_op = ALU_ADD;
      ALUOP_SUB:  alu_op = ALU_SUB;
      ALUOP_ADD2: alu_op = ALU_ADD;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_SUB: alu_op = ALU_SUB;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_NOR: alu_op = ALU_NOR;
          FUNCT_SLT: alu_op = ALU_SLT;
          default:   alu_op = ALU_ADD;
        endcase
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: operand forwarding, ALU,
// branch resolution and the EX/MEM pipeline register with stall/flush.
import ex_stage_pkg::*;

module ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     reg_data1,
  input  logic [DATA_W-1:0]     reg_data2,
  input  logic [DATA_W-1:0]     sign_ext_offset,
  input  logic [4:0]            rs,
  input  logic [4:0]            rt,
  input  logic [4:0]            rd,
  input  logic [CTRL_IN_W-1:0]  ctrl_in,
  input  logic [4:0]            wb_rd,
  input  logic                  wb_RegWrite,
  input  logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     alu_result_out,
  output logic [DATA_W-1:0]     store_data_out,
  output logic [4:0]            dest_reg_out,
  output logic [CTRL_OUT_W-1:0] ctrl_out,
  output logic                  branch_taken_out,
  output logic [DATA_W-1:0]     branch_target_out
);

  logic              ex_mem_regwrite;
  logic              exmem_hit_a, exmem_hit_b;
  logic              memwb_hit_a, memwb_hit_b;
  logic [DATA_W-1:0] fwd_a, fwd_b, op_b;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] branch_target;
  logic [4:0]        dest_reg;
  logic              zero;
  alu_op_e           alu_op;

  // Forwarding: the EX/MEM register (possibly held by a stall) beats MEM/WB;
  // register 0 is hard-wired to zero and is never forwarded.
  assign ex_mem_regwrite = ctrl_out[CTRL_REGWRITE];
  assign exmem_hit_a = ex_mem_regwrite && (dest_reg_out != 5'd0) && (dest_reg_out == rs);
  assign exmem_hit_b = ex_mem_regwrite && (dest_reg_out != 5'd0) && (dest_reg_out == rt);
  assign memwb_hit_a = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rs);
  assign memwb_hit_b = wb_RegWrite && (wb_rd != 5'd0) && (wb_rd == rt);

  assign fwd_a = exmem_hit_a ? alu_result_out : (memwb_hit_a ? wb_data : reg_data1);
  assign fwd_b = exmem_hit_b ? alu_result_out : (memwb_hit_b ? wb_data : reg_data2);
  assign op_b  = ctrl_in[CTRL_ALUSRC] ? sign_ext_offset : fwd_b;

  alu_ctrl u_alu_ctrl (
    .alu_op_sel (ctrl_in[CTRL_ALUOP_HI:CTRL_ALUOP_LO]),
    .funct      (sign_ext_offset[5:0]),
    .alu_op     (alu_op)
  );

  // ALU: modulo-2^DATA_W arithmetic, signed set-less-than zero-extended
  always_comb begin
    alu_res = fwd_a + op_b;
    unique case (alu_op)
      ALU_ADD: alu_res = fwd_a + op_b;
      ALU_SUB: alu_res = fwd_a - op_b;
      ALU_AND: alu_res = fwd_a & op_b;
      ALU_OR:  alu_res = fwd_a | op_b;
      ALU_NOR: alu_res = ~(fwd_a | op_b);
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
      default: alu_res = fwd_a + op_b;
    endcase
  end

  assign zero          = (alu_res == '0);
  assign branch_target = pc_plus4 + (sign_ext_offset << 2);
  assign dest_reg      = ctrl_in[CTRL_REGDST] ? rd : rt;

  // EX/MEM register: reset > flush (bubble) > stall (hold) > load
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      alu_result_out    <= '0;
      store_data_out    <= '0;
      dest_reg_out      <= '0;
      ctrl_out          <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else if (flush) begin
      alu_result_out    <= '0;
      store_data_out    <= '0;
      dest_reg_out      <= '0;
      ctrl_out          <= '0;
      branch_taken_out  <= 1'b0;
      branch_target_out <= '0;
    end else if (!stall) begin
      alu_result_out    <= alu_res;
      store_data_out    <= fwd_b;
      dest_reg_out      <= dest_reg;
      ctrl_out          <= ctrl_in[CTRL_OUT_W-1:0];
      branch_taken_out  <= ctrl_in[CTRL_PCSRC] & zero;
      branch_target_out <= branch_target;
    end
  end

endmodule
